// File: rtl/wb_regfile.sv
// Write-back source select, 8x16 architectural register file, forwarding tap and retired counter.
// Optional same-cycle write-through on the read ports when WB_BYPASS_EN is defined.
module wb_regfile (
   input  logic        clock,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [2:0]  wb_ctrl_in,
   input  logic [2:0]  dest_in,
   input  logic [15:0] alu_in,
   input  logic [15:0] mem_data_in,
   input  logic [15:0] zero_pad_in,
   input  logic [15:0] pc_plus1_in,
   input  logic [2:0]  rd_addr_a,
   input  logic [2:0]  rd_addr_b,
   output logic [15:0] rd_data_a,
   output logic [15:0] rd_data_b,
   output logic        fwd_en,
   output logic [2:0]  fwd_dest,
   output logic [15:0] fwd_data,
   output logic [15:0] retired_count
);

   logic [15:0] regs [8];
   logic [15:0] wb_data;

   always_comb begin
      wb_data = alu_in;
      case (wb_ctrl_in[1:0])
         2'b00:   wb_data = alu_in;
         2'b01:   wb_data = mem_data_in;
         2'b10:   wb_data = zero_pad_in;
         default: wb_data = pc_plus1_in;
      endcase
   end

   assign fwd_en   = valid_in & wb_ctrl_in[2];
   assign fwd_dest = dest_in;
   assign fwd_data = wb_data;

   // Reset wins over any coincident write or count.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
         retired_count <= 16'h0000;
      end else begin
         if (fwd_en) regs[dest_in] <= wb_data;
         if (valid_in) retired_count <= retired_count + 16'd1;
      end
   end

`ifdef WB_BYPASS_EN
   assign rd_data_a = (fwd_en && (rd_addr_a == dest_in)) ? wb_data : regs[rd_addr_a];
   assign rd_data_b = (fwd_en && (rd_addr_b == dest_in)) ? wb_data : regs[rd_addr_b];
`else
   assign rd_data_a = regs[rd_addr_a];
   assign rd_data_b = regs[rd_addr_b];
`endif

endmodule
